// File: rtl/ecp5_eclk_init_seq.sv
// rtl/ecp5_eclk_init_seq.sv - ECP5 DDR clock tree bring-up and DLL update sequencer
module ecp5_eclk_init_seq #(
  parameter int LOCK_CYCLES = 64,
  parameter int STEP_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic upd_req,
  output logic dll_freeze,
  output logic eclk_stop,
  output logic div_rst,
  output logic pause,
  output logic dll_update,
  output logic ready,
  output logic upd_ack
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > STEP_CYCLES) ? LOCK_CYCLES : STEP_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_FREEZE,
    S_STOP,
    S_DIVREL,
    S_START,
    S_UNFREEZE,
    S_READY,
    S_PAUSE,
    S_UPDATE,
    S_UNPAUSE
  } state_t;

  state_t        state, state_nxt, step_succ;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lock_m, lock_s;
  logic          ack_nxt;
  logic          freeze_nxt, stop_nxt, div_rst_nxt, pause_nxt, update_nxt, ready_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // State, dwell counter and registered outputs (decoded from the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_LOCK;
      cnt        <= LOCK_LOAD;
      dll_freeze <= 1'b0;
      eclk_stop  <= 1'b0;
      div_rst    <= 1'b1;
      pause      <= 1'b0;
      dll_update <= 1'b0;
      ready      <= 1'b0;
      upd_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dll_freeze <= freeze_nxt;
      eclk_stop  <= stop_nxt;
      div_rst    <= div_rst_nxt;
      pause      <= pause_nxt;
      dll_update <= update_nxt;
      ready      <= ready_nxt;
      upd_ack    <= ack_nxt;
    end
  end

  // Next state: lock loss wins, then lock qualification, READY requests and timed steps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    case (state)
      S_FREEZE:   step_succ = S_STOP;
      S_STOP:     step_succ = S_DIVREL;
      S_DIVREL:   step_succ = S_START;
      S_START:    step_succ = S_UNFREEZE;
      S_UNFREEZE: step_succ = S_READY;
      S_PAUSE:    step_succ = S_UPDATE;
      S_UPDATE:   step_succ = S_UNPAUSE;
      S_UNPAUSE:  step_succ = S_READY;
      default:    step_succ = S_WAIT_LOCK;
    endcase

    if (state != S_WAIT_LOCK && !lock_s) begin
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = LOCK_LOAD;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_nxt = LOCK_LOAD;
          end else if (cnt == '0) begin
            state_nxt = S_FREEZE;
            cnt_nxt   = STEP_LOAD;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_READY: begin
          if (upd_req) begin
            state_nxt = S_PAUSE;
            cnt_nxt   = STEP_LOAD;
          end
        end
        default: begin
          if (cnt == '0) begin
            state_nxt = step_succ;
            cnt_nxt   = STEP_LOAD;
            ack_nxt   = (state == S_UNPAUSE);
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Output decode of the next state
  always_comb begin
    freeze_nxt  = 1'b0;
    stop_nxt    = 1'b0;
    div_rst_nxt = 1'b0;
    pause_nxt   = 1'b0;
    update_nxt  = 1'b0;
    ready_nxt   = 1'b0;
    case (state_nxt)
      S_WAIT_LOCK: div_rst_nxt = 1'b1;
      S_FREEZE: begin
        freeze_nxt  = 1'b1;
        div_rst_nxt = 1'b1;
      end
      S_STOP: begin
        freeze_nxt  = 1'b1;
        stop_nxt    = 1'b1;
        div_rst_nxt = 1'b1;
      end
      S_DIVREL: begin
        freeze_nxt = 1'b1;
        stop_nxt   = 1'b1;
      end
      S_START:   freeze_nxt = 1'b1;
      S_READY:   ready_nxt  = 1'b1;
      S_PAUSE:   pause_nxt  = 1'b1;
      S_UPDATE: begin
        pause_nxt  = 1'b1;
        update_nxt = 1'b1;
      end
      S_UNPAUSE: pause_nxt  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ecp5_eclk_init_seq.sv
// tb/tb_ecp5_eclk_init_seq.sv - self-checking bench for ecp5_eclk_init_seq
module tb_ecp5_eclk_init_seq;

  localparam int LA = 64, SA = 8;
  localparam int LB = 1,  SB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0, upd_req = 1'b0;
  logic pll_lock_b = 1'b1, upd_req_b = 1'b0;
  logic dll_freeze, eclk_stop, div_rst, pause, dll_update, ready, upd_ack;
  logic dll_freeze_b, eclk_stop_b, div_rst_b, pause_b, dll_update_b, ready_b, upd_ack_b;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  always #5 clk = ~clk;

  ecp5_eclk_init_seq #(.LOCK_CYCLES(LA), .STEP_CYCLES(SA)) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .upd_req(upd_req),
    .dll_freeze(dll_freeze), .eclk_stop(eclk_stop), .div_rst(div_rst), .pause(pause),
    .dll_update(dll_update), .ready(ready), .upd_ack(upd_ack)
  );

  ecp5_eclk_init_seq #(.LOCK_CYCLES(LB), .STEP_CYCLES(SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock_b), .upd_req(upd_req_b),
    .dll_freeze(dll_freeze_b), .eclk_stop(eclk_stop_b), .div_rst(div_rst_b), .pause(pause_b),
    .dll_update(dll_update_b), .ready(ready_b), .upd_ack(upd_ack_b)
  );

  // Model: consecutive-lock run length drives bring-up phase, an elapsed count drives updates
  typedef struct {
    bit m1;
    bit m2;
    int run;
    bit done;
    int u;
    bit ack;
  } mstate_t;

  function automatic mstate_t minit();
    mstate_t s;
    s.m1 = 0; s.m2 = 0; s.run = 0; s.done = 0; s.u = -1; s.ack = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit lock_in, input bit req,
                                    input int l, input int st);
    mstate_t n = s;
    n.ack = 0;
    if (!s.m2) begin
      n.run = 0; n.done = 0; n.u = -1;
    end else if (!s.done) begin
      n.run = s.run + 1;
      if (n.run >= l + 5 * st) n.done = 1;
    end else if (s.u < 0) begin
      if (req) n.u = 0;
    end else begin
      n.u = s.u + 1;
      if (n.u == 3 * st) begin
        n.u = -1;
        n.ack = 1;
      end
    end
    n.m2 = s.m1;
    n.m1 = lock_in;
    return n;
  endfunction

  // {freeze, stop, div_rst, pause, update, ready, ack}
  function automatic logic [6:0] mexp(input mstate_t s, input int l, input int st);
    logic [5:0] o;
    int idx;
    if (!s.done) begin
      idx = (s.run < l) ? 0 : 1 + (s.run - l) / st;
      case (idx)
        0: o = 6'b001000;
        1: o = 6'b101000;
        2: o = 6'b111000;
        3: o = 6'b110000;
        4: o = 6'b100000;
        default: o = 6'b000000;
      endcase
    end else if (s.u < 0) begin
      o = 6'b000001;
    end else begin
      case (s.u / st)
        1: o = 6'b000110;
        default: o = 6'b000100;
      endcase
    end
    return {o, s.ack};
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = minit();
      mb = minit();
    end else begin
      ma = mstep(ma, pll_lock, upd_req, LA, SA);
      mb = mstep(mb, pll_lock_b, upd_req_b, LB, SB);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    logic [6:0] act_a, act_b, exp_a, exp_b;
    act_a = {dll_freeze, eclk_stop, div_rst, pause, dll_update, ready, upd_ack};
    act_b = {dll_freeze_b, eclk_stop_b, div_rst_b, pause_b, dll_update_b, ready_b, upd_ack_b};
    exp_a = mexp(ma, LA, SA);
    exp_b = mexp(mb, LB, SB);
    n_checks += 2;
    if (act_a !== exp_a) begin
      n_fail++;
      $display("FAIL model_a edge %0d: got %b expected %b", cyc, act_a, exp_a);
    end
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL model_b edge %0d: got %b expected %b", cyc, act_b, exp_b);
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pll_lock = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_vals", {dll_freeze, eclk_stop, div_rst, pause, dll_update, ready, upd_ack}, 7'b0010000);
    rst_n = 1'b1;

    // Small-parameter instance: bring-up and 3-cycle update
    goto(7);  chk("b_ready_7", ready_b, 1'b0);
    goto(8);  chk("b_ready_8", ready_b, 1'b1);
    goto(20); upd_req_b = 1'b1;
    goto(21); upd_req_b = 1'b0;
    chk("b_pause_21", {pause_b, dll_update_b, ready_b}, 3'b100);
    goto(22); chk("b_update_22", {pause_b, dll_update_b, ready_b}, 3'b110);
    goto(23); chk("b_unpause_23", {pause_b, dll_update_b, ready_b}, 3'b100);
    goto(24); chk("b_ack_24", {pause_b, ready_b, upd_ack_b}, 3'b011);

    // Clean bring-up edges
    goto(65);  chk("freeze_65", dll_freeze, 1'b0);
    goto(66);  chk("freeze_66", dll_freeze, 1'b1);
    goto(73);  chk("stop_73", eclk_stop, 1'b0);
    goto(74);  chk("stop_74", eclk_stop, 1'b1);
    goto(81);  chk("divrst_81", div_rst, 1'b1);
    goto(82);  chk("divrel_82", {dll_freeze, eclk_stop, div_rst}, 3'b110);
    goto(90);  chk("stop_90", eclk_stop, 1'b0);
    goto(98);  chk("freeze_98", dll_freeze, 1'b0);
    goto(105); chk("ready_105", ready, 1'b0);
    goto(106); chk("ready_106", ready, 1'b1);

    // Single update request sampled at edge 200
    goto(199); upd_req = 1'b1;
    goto(200); upd_req = 1'b0;
    chk("upd_200", {pause, dll_update, ready}, 3'b100);
    goto(207); chk("upd_207", dll_update, 1'b0);
    goto(208); chk("upd_208", dll_update, 1'b1);
    goto(215); chk("upd_215", dll_update, 1'b1);
    goto(216); chk("upd_216", dll_update, 1'b0);
    goto(223); chk("upd_223", {pause, ready, upd_ack}, 3'b100);
    goto(224); chk("upd_224", {pause, ready, upd_ack}, 3'b011);
    goto(225); chk("upd_225", upd_ack, 1'b0);

    // Held request re-triggers one cycle after the ack
    goto(230); upd_req = 1'b1;
    goto(255); chk("held_ack_255", {ready, upd_ack}, 2'b11);
    goto(256); chk("held_pause_256", {pause, ready}, 2'b10);
    upd_req = 1'b0;

    // Lock loss mid-UPDATE, then re-lock
    goto(300); upd_req = 1'b1;
    goto(301); upd_req = 1'b0;
    goto(311); pll_lock = 1'b0;
    goto(313); chk("loss_313", dll_update, 1'b1);
    goto(314); chk("loss_314", {div_rst, ready, pause, upd_ack}, 4'b1000);
    goto(320); pll_lock = 1'b1;
    goto(425); chk("relock_425", ready, 1'b0);
    goto(426); chk("relock_426", ready, 1'b1);

    // Asynchronous reset from READY
    goto(440);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_ready", {div_rst, ready}, 2'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // upd_req in STOP is ignored; async reset in DIVREL
    goto(76); upd_req = 1'b1;
    goto(77); upd_req = 1'b0;
    chk("stop_ignore_77", {eclk_stop, pause}, 2'b10);
    goto(85);
    chk("divrel_85", {dll_freeze, eclk_stop, div_rst}, 3'b110);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_divrel", {dll_freeze, eclk_stop, div_rst, ready}, 4'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Lock glitch at edge 40 restarts the lock count
    goto(39); pll_lock = 1'b0;
    goto(40); pll_lock = 1'b1;
    goto(106); chk("glitch_106", ready, 1'b0);
    goto(145); chk("glitch_145", ready, 1'b0);
    goto(146); chk("glitch_146", ready, 1'b1);
    goto(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
